// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
// Module   : config_loader
// Purpose  : Streams per-PE configuration entries from a valid/stop source
//            into a PE array. Entries are taken in PE-major order with the
//            context index running fastest. When the final entry has been
//            written, the block issues a single start_exec pulse.
// Option   : define CONFIG_LOADER_ID_CHECK_EN so that each entry's cfg_pe_id
//            is checked against the expected PE. A mismatch locks the FSM in
//            ERROR until reset.
// Revision : 1.0 - initial release
// ============================================================================
module config_loader #(
    parameter int PE_NUM                  = 16,
    parameter int PE_ID_WIDTH             = 4,
    parameter int CONTEXT_SIZE_BIT_LENGTH = 4,
    parameter int INPUT_NUM_BIT_LENGTH    = 3,
    parameter int NEIGHBOR_PE_NUM         = 4,
    parameter int OPERATION_BIT_LENGTH    = 4,
    parameter int DATA_WIDTH              = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               load_start,
    input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] load_context_max_id,
    input  logic                               cfg_valid,
    output logic                               cfg_stop,
    input  logic [PE_ID_WIDTH-1:0]             cfg_pe_id,
    input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_PE_index_1,
    input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_PE_index_2,
    input  logic [NEIGHBOR_PE_NUM-1:0]         cfg_output_PE_index,
    input  logic [OPERATION_BIT_LENGTH-1:0]    cfg_op,
    input  logic [DATA_WIDTH-1:0]              cfg_const_data,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
    output logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index,
    output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
    output logic [DATA_WIDTH-1:0]              config_const_data,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
    output logic [PE_NUM-1:0]                  write_config_data,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
    output logic                               start_exec,
    output logic                               busy,
    output logic                               done,
    output logic                               error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FLUSH = 3'd2,
        S_START = 3'd3,
        S_RUN   = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t                             r_state;
    state_t                             w_next;
    logic [PE_ID_WIDTH-1:0]             r_pe_cnt;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] r_ctx_cnt;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] r_max_id;
    logic [PE_NUM-1:0]                  r_wr;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] r_idx;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    r_in1;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    r_in2;
    logic [NEIGHBOR_PE_NUM-1:0]         r_outp;
    logic [OPERATION_BIT_LENGTH-1:0]    r_op;
    logic [DATA_WIDTH-1:0]              r_data;

    logic w_accept;
    logic w_load_req;
    logic w_last;
    logic w_ctx_wrap;
    logic w_id_bad;
    logic w_write;

    // A load is only honoured from IDLE or RUN; any other state ignores it.
    assign w_load_req = load_start && ((r_state == S_IDLE) || (r_state == S_RUN));
    assign w_accept   = (r_state == S_LOAD) && cfg_valid;
    assign w_ctx_wrap = (r_ctx_cnt == r_max_id);
    assign w_last     = w_ctx_wrap && (r_pe_cnt == PE_ID_WIDTH'(PE_NUM - 1));

`ifdef CONFIG_LOADER_ID_CHECK_EN
    assign w_id_bad = (cfg_pe_id != r_pe_cnt);
`else
    // The PE id is deliberately ignored in this build.
    logic w_unused_pe_id;
    assign w_unused_pe_id = ^cfg_pe_id;
    assign w_id_bad       = 1'b0;
`endif

    assign w_write = w_accept && !w_id_bad;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode and state-derived status outputs.
    always_comb begin
        w_next     = r_state;
        cfg_stop   = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        start_exec = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_start) w_next = S_LOAD;
            end
            S_LOAD: begin
                cfg_stop = 1'b0;
                busy     = 1'b1;
                if (w_accept) begin
                    if (w_id_bad)    w_next = S_ERROR;
                    else if (w_last) w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy   = 1'b1;
                w_next = S_START;
            end
            S_START: begin
                busy       = 1'b1;
                start_exec = 1'b1;
                w_next     = S_RUN;
            end
            S_RUN: begin
                done = 1'b1;
                if (load_start) w_next = S_LOAD;
            end
            S_ERROR: begin
`ifdef CONFIG_LOADER_ID_CHECK_EN
                error = 1'b1;
`else
                error = 1'b0;
`endif
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Entry position counters and the latched per-PE context count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pe_cnt  <= '0;
            r_ctx_cnt <= '0;
            r_max_id  <= '0;
        end else if (w_load_req) begin
            r_pe_cnt  <= '0;
            r_ctx_cnt <= '0;
            r_max_id  <= load_context_max_id;
        end else if (w_write) begin
            if (w_ctx_wrap) begin
                r_ctx_cnt <= '0;
                r_pe_cnt  <= r_pe_cnt + 1'b1;
            end else begin
                r_ctx_cnt <= r_ctx_cnt + 1'b1;
            end
        end
    end

    // Broadcast register: strobe lasts one cycle, fields hold between writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr   <= '0;
            r_idx  <= '0;
            r_in1  <= '0;
            r_in2  <= '0;
            r_outp <= '0;
            r_op   <= '0;
            r_data <= '0;
        end else begin
            r_wr <= w_write ? (PE_NUM'(1) << r_pe_cnt) : '0;
            if (w_write) begin
                r_idx  <= r_ctx_cnt;
                r_in1  <= cfg_input_PE_index_1;
                r_in2  <= cfg_input_PE_index_2;
                r_outp <= cfg_output_PE_index;
                r_op   <= cfg_op;
                r_data <= cfg_const_data;
            end
        end
    end

    assign write_config_data       = r_wr;
    assign config_index            = r_idx;
    assign config_input_PE_index_1 = r_in1;
    assign config_input_PE_index_2 = r_in2;
    assign config_output_PE_index  = r_outp;
    assign config_op               = r_op;
    assign config_const_data       = r_data;
    assign mapping_context_max_id  = r_max_id;

endmodule
`default_nettype wire

// File: tb/tb_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_config_loader
// Purpose  : Self-checking bench for config_loader (PE_NUM=4) using a
//            scoreboard of expected write-strobe cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_config_loader;

    localparam int PE_NUM = 4;
    localparam int PEW    = 2;
    localparam int CTXW   = 4;
    localparam int INW    = 3;
    localparam int NBR    = 4;
    localparam int OPW    = 4;
    localparam int DW     = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            load_start;
    logic [CTXW-1:0] load_context_max_id;
    logic            cfg_valid;
    logic            cfg_stop;
    logic [PEW-1:0]  cfg_pe_id;
    logic [INW-1:0]  cfg_input_PE_index_1, cfg_input_PE_index_2;
    logic [NBR-1:0]  cfg_output_PE_index;
    logic [OPW-1:0]  cfg_op;
    logic [DW-1:0]   cfg_const_data;
    logic [INW-1:0]  config_input_PE_index_1, config_input_PE_index_2;
    logic [NBR-1:0]  config_output_PE_index;
    logic [OPW-1:0]  config_op;
    logic [DW-1:0]   config_const_data;
    logic [CTXW-1:0] config_index;
    logic [PE_NUM-1:0] write_config_data;
    logic [CTXW-1:0] mapping_context_max_id;
    logic            start_exec, busy, done, error;

    config_loader #(
        .PE_NUM(PE_NUM), .PE_ID_WIDTH(PEW), .CONTEXT_SIZE_BIT_LENGTH(CTXW),
        .INPUT_NUM_BIT_LENGTH(INW), .NEIGHBOR_PE_NUM(NBR),
        .OPERATION_BIT_LENGTH(OPW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .load_context_max_id(load_context_max_id),
        .cfg_valid(cfg_valid), .cfg_stop(cfg_stop), .cfg_pe_id(cfg_pe_id),
        .cfg_input_PE_index_1(cfg_input_PE_index_1),
        .cfg_input_PE_index_2(cfg_input_PE_index_2),
        .cfg_output_PE_index(cfg_output_PE_index),
        .cfg_op(cfg_op), .cfg_const_data(cfg_const_data),
        .config_input_PE_index_1(config_input_PE_index_1),
        .config_input_PE_index_2(config_input_PE_index_2),
        .config_output_PE_index(config_output_PE_index),
        .config_op(config_op), .config_const_data(config_const_data),
        .config_index(config_index), .write_config_data(write_config_data),
        .mapping_context_max_id(mapping_context_max_id),
        .start_exec(start_exec), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              due;
        logic [3:0]      strobe;
        logic [CTXW-1:0] idx;
        logic [INW-1:0]  in1;
        logic [INW-1:0]  in2;
        logic [NBR-1:0]  outp;
        logic [OPW-1:0]  op;
        logic [DW-1:0]   data;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    int   cyc       = 0;
    int   exp_start = -1;
    int   checks    = 0;
    int   errors    = 0;

    // Cycle counter used to timestamp expected strobes.
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every cycle either an expected write or no write.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            checks++; errors++;
            $display("FAIL missing_write: due cycle %0d, now %0d, strobe got %b exp %b",
                     e.due, cyc, write_config_data, e.strobe);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            checks++;
            if ({write_config_data, config_index, config_input_PE_index_1,
                 config_input_PE_index_2, config_output_PE_index, config_op,
                 config_const_data} !==
                {e.strobe, e.idx, e.in1, e.in2, e.outp, e.op, e.data}) begin
                errors++;
                $display("FAIL write: cyc %0d got strb=%b idx=%0d op=%h data=%h exp strb=%b idx=%0d op=%h data=%h",
                         cyc, write_config_data, config_index, config_op, config_const_data,
                         e.strobe, e.idx, e.op, e.data);
            end
        end else begin
            checks++;
            if (write_config_data !== '0) begin
                errors++;
                $display("FAIL spurious_write: cyc %0d got strobe %b exp 0000", cyc, write_config_data);
            end
        end
        checks++;
        if (start_exec !== (cyc == exp_start)) begin
            errors++;
            $display("FAIL start_exec: cyc %0d got %b exp %b", cyc, start_exec, (cyc == exp_start));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full load of PE_NUM x (maxid+1) entries; optional idle gaps and ignored load_start pokes.
    task automatic do_load(input int maxid, input bit gaps, input bit poke);
        exp_t e;
        load_context_max_id = CTXW'(maxid);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_context_max_id = '0;
        checks++;
        if ({busy, cfg_stop} !== 2'b10) begin
            errors++;
            $display("FAIL load_entry_status: got busy=%b stop=%b exp busy=1 stop=0", busy, cfg_stop);
        end
        checks++;
        if (mapping_context_max_id !== CTXW'(maxid)) begin
            errors++;
            $display("FAIL max_id_latch: got %0d exp %0d", mapping_context_max_id, maxid);
        end
        for (int pe = 0; pe < PE_NUM; pe++) begin
            for (int c = 0; c <= maxid; c++) begin
                if (gaps) begin
                    cfg_valid = 1'b0;
                    if (poke) begin
                        load_start = 1'b1;
                        load_context_max_id = 4'd7;
                    end
                    step();
                    load_start = 1'b0;
                    checks++;
                    if (mapping_context_max_id !== CTXW'(maxid)) begin
                        errors++;
                        $display("FAIL max_id_hold: got %0d exp %0d", mapping_context_max_id, maxid);
                    end
                end
                cfg_valid            = 1'b1;
                cfg_input_PE_index_1 = INW'($urandom);
                cfg_input_PE_index_2 = INW'($urandom);
                cfg_output_PE_index  = NBR'($urandom);
                cfg_op               = OPW'($urandom);
                cfg_const_data       = DW'($urandom);
`ifdef CONFIG_LOADER_ID_CHECK_EN
                cfg_pe_id = PEW'(pe);
`else
                cfg_pe_id = PEW'($urandom);
`endif
                e.due    = cyc + 1;
                e.strobe = 4'(4'b0001 << pe);
                e.idx    = CTXW'(c);
                e.in1    = cfg_input_PE_index_1;
                e.in2    = cfg_input_PE_index_2;
                e.outp   = cfg_output_PE_index;
                e.op     = cfg_op;
                e.data   = cfg_const_data;
                sb.push_back(e);
                last_e = e;
                if (pe == PE_NUM - 1 && c == maxid) exp_start = cyc + 2;
                step();
            end
        end
        cfg_valid = 1'b0;
        step();
        step();
        step();
        checks++;
        if ({done, busy, cfg_stop, error} !== 4'b1010) begin
            errors++;
            $display("FAIL run_status: got done=%b busy=%b stop=%b err=%b exp 1 0 1 0",
                     done, busy, cfg_stop, error);
        end
        checks++;
        if ({config_index, config_op, config_const_data} !== {last_e.idx, last_e.op, last_e.data}) begin
            errors++;
            $display("FAIL field_hold: got idx=%0d op=%h data=%h exp idx=%0d op=%h data=%h",
                     config_index, config_op, config_const_data, last_e.idx, last_e.op, last_e.data);
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; load_start = 1'b1; cfg_valid = 1'b1; load_context_max_id = 4'd5;
        step();
        step();
        checks++;
        if ({write_config_data, start_exec, cfg_stop, busy, done, error} !== {4'b0000, 1'b0, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL reset_status: got strb=%b st=%b stop=%b busy=%b done=%b err=%b",
                     write_config_data, start_exec, cfg_stop, busy, done, error);
        end
        checks++;
        if ({config_index, mapping_context_max_id, config_op, config_const_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: got idx=%0d max=%0d op=%h data=%h exp all 0",
                     config_index, mapping_context_max_id, config_op, config_const_data);
        end
        reset = 1'b0; load_start = 1'b0; cfg_valid = 1'b0; load_context_max_id = '0;
        step();
        checks++;
        if ({busy, cfg_stop} !== 2'b01) begin
            errors++;
            $display("FAIL idle_status: got busy=%b stop=%b exp busy=0 stop=1", busy, cfg_stop);
        end
    endtask

    task automatic test_back_to_back();  do_load(1, 1'b0, 1'b0); endtask
    task automatic test_valid_toggle();  do_load(1, 1'b1, 1'b1); endtask
    task automatic test_max_zero();      do_load(0, 1'b0, 1'b0); endtask
    task automatic test_reload_from_run(); do_load(2, 1'b0, 1'b0); endtask

    task automatic test_mid_reset();
        exp_t e;
        load_context_max_id = 4'd1;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cfg_valid = 1'b1;
            cfg_op = OPW'(k + 1); cfg_const_data = DW'(16'hA000 + k);
            cfg_input_PE_index_1 = INW'(k); cfg_input_PE_index_2 = INW'(k + 2);
            cfg_output_PE_index = NBR'(k + 5); cfg_pe_id = PEW'(k / 2);
            e.due = cyc + 1; e.strobe = 4'(4'b0001 << (k / 2)); e.idx = CTXW'(k % 2);
            e.in1 = cfg_input_PE_index_1; e.in2 = cfg_input_PE_index_2;
            e.outp = cfg_output_PE_index; e.op = cfg_op; e.data = cfg_const_data;
            sb.push_back(e);
            step();
        end
        cfg_valid = 1'b0;
        reset = 1'b1;
        step();
        checks++;
        if ({write_config_data, start_exec, cfg_stop, busy, done, error} !== {4'b0000, 1'b0, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL midreset_status: got strb=%b st=%b stop=%b busy=%b done=%b err=%b",
                     write_config_data, start_exec, cfg_stop, busy, done, error);
        end
        checks++;
        if ({config_index, mapping_context_max_id, config_input_PE_index_1, config_input_PE_index_2,
             config_output_PE_index, config_op, config_const_data} !== '0) begin
            errors++;
            $display("FAIL midreset_data: got idx=%0d max=%0d op=%h data=%h exp all 0",
                     config_index, mapping_context_max_id, config_op, config_const_data);
        end
        reset = 1'b0;
        step();
        do_load(0, 1'b0, 1'b0);
    endtask

`ifdef CONFIG_LOADER_ID_CHECK_EN
    task automatic test_id_check();
        exp_t e;
        load_context_max_id = 4'd1;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        cfg_valid = 1'b1; cfg_pe_id = 2'd0; cfg_op = 4'h3; cfg_const_data = 16'h1234;
        cfg_input_PE_index_1 = 3'd1; cfg_input_PE_index_2 = 3'd2; cfg_output_PE_index = 4'h9;
        e.due = cyc + 1; e.strobe = 4'b0001; e.idx = 4'd0; e.in1 = 3'd1; e.in2 = 3'd2;
        e.outp = 4'h9; e.op = 4'h3; e.data = 16'h1234;
        sb.push_back(e);
        step();
        cfg_pe_id = 2'd3; cfg_op = 4'hE; cfg_const_data = 16'hDEAD;
        step();
        cfg_valid = 1'b0;
        checks++;
        if ({error, cfg_stop, busy, done} !== 4'b1100) begin
            errors++;
            $display("FAIL id_error_status: got err=%b stop=%b busy=%b done=%b exp 1 1 0 0",
                     error, cfg_stop, busy, done);
        end
        load_context_max_id = 4'd2;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        step();
        checks++;
        if ({error, mapping_context_max_id} !== {1'b1, 4'd1}) begin
            errors++;
            $display("FAIL error_sticky: got err=%b max=%0d exp err=1 max=1", error, mapping_context_max_id);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL error_cleared: got %b exp 0", error);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; load_start = 1'b0; cfg_valid = 1'b0; load_context_max_id = '0;
        cfg_pe_id = '0; cfg_input_PE_index_1 = '0; cfg_input_PE_index_2 = '0;
        cfg_output_PE_index = '0; cfg_op = '0; cfg_const_data = '0;
        test_reset();
        test_back_to_back();
        test_valid_toggle();
        test_max_zero();
        test_reload_from_run();
        test_mid_reset();
`ifdef CONFIG_LOADER_ID_CHECK_EN
        test_id_check();
`endif
        step();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending exp 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
